// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port 8K x 8 video RAM between
// the VGA fetch path (hard priority) and the CPU bus (req/ack, free slots).
// Grant at edge k, RAM samples at k+1, read data captured at k+2.
// Optional build macro: VRAM_ARB_STATS_EN enables the 16-bit conflict counter.
module vram_arbiter #(
  parameter int AW           = 13,
  parameter int DW           = 8,
  parameter int CPU_MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_valid,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_starve,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stat_conflicts
);

  typedef enum logic [1:0] {CPU_IDLE, CPU_WAIT, CPU_BUSY, CPU_ACK} cpu_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU_RD, OWN_CPU_WR} owner_t;

  // Wait counter is 5 bits and saturates at 31.
  localparam int             WCW       = 5;
  localparam logic [WCW-1:0] WAIT_MAX  = '1;
  localparam logic [WCW-1:0] STARVE_AT = WCW'(CPU_MAX_WAIT);

  cpu_state_t     state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           starve_q, starve_d;
  logic           cpu_grant;

  owner_t         own1_q, own1_d;
  owner_t         own2_q, own2_d;

  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic           mem_we_q, mem_we_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           vid_valid_q, vid_valid_d;
  logic [DW-1:0]  vid_data_q, vid_data_d;
  logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;

  // CPU FSM next state, grant decision, wait counter and sticky starvation flag.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cpu_grant = 1'b0;
    case (state_q)
      CPU_IDLE: begin
        if (cpu_req) begin
          if (vid_req) begin
            state_d = CPU_WAIT;
            wait_d  = WCW'(1);
          end else begin
            state_d   = CPU_BUSY;
            cpu_grant = 1'b1;
          end
        end
      end
      CPU_WAIT: begin
        if (!cpu_req) begin
          // Requester gave up: abandon the access, no ack.
          state_d = CPU_IDLE;
          wait_d  = '0;
        end else if (!vid_req) begin
          state_d   = CPU_BUSY;
          cpu_grant = 1'b1;
          wait_d    = '0;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
        end
      end
      CPU_BUSY: begin
        // The CPU access reaches the capture stage exactly two edges after grant.
        if ((own2_q == OWN_CPU_RD) || (own2_q == OWN_CPU_WR)) begin
          state_d = CPU_ACK;
        end
      end
      CPU_ACK: begin
        // cpu_req is deliberately ignored here, giving a 4-cycle minimum period.
        state_d = CPU_IDLE;
      end
      default: state_d = CPU_IDLE;
    endcase
    starve_d = starve_q | (wait_d >= STARVE_AT);
  end

  // RAM port drive and owner/capture pipeline; video always wins the slot.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    own1_d      = OWN_NONE;
    if (vid_req) begin
      mem_addr_d = vid_addr;
      own1_d     = OWN_VID;
    end else if (cpu_grant) begin
      mem_addr_d = cpu_addr;
      mem_we_d   = cpu_we;
      own1_d     = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
      if (cpu_we) begin
        mem_wdata_d = cpu_wdata;
      end
    end
    own2_d      = own1_q;
    vid_valid_d = (own2_q == OWN_VID);
    vid_data_d  = (own2_q == OWN_VID) ? mem_rdata : vid_data_q;
    cpu_rdata_d = (own2_q == OWN_CPU_RD) ? mem_rdata : cpu_rdata_q;
  end

  // State and datapath registers; reset discards any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CPU_IDLE;
      wait_q      <= '0;
      starve_q    <= 1'b0;
      own1_q      <= OWN_NONE;
      own2_q      <= OWN_NONE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      own1_q      <= own1_d;
      own2_q      <= own2_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign vid_valid  = vid_valid_q;
  assign vid_data   = vid_data_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ack    = (state_q == CPU_ACK);
  assign cpu_starve = starve_q;

`ifdef VRAM_ARB_STATS_EN
  logic        conflict;
  logic [15:0] stat_q, stat_d;

  // A conflict is a video request while the CPU sits in, or is entering, WAIT.
  always_comb begin
    conflict = vid_req && ((state_q == CPU_WAIT) || ((state_q == CPU_IDLE) && cpu_req));
    stat_d   = stat_q;
    if (conflict && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  // Saturating conflict counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_conflicts = stat_q;
`else
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a cycle-count reference model.
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int MAX_WAIT = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          vid_valid, cpu_ack, cpu_starve, mem_we;
  logic [DW-1:0] vid_data, cpu_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   stat_conflicts;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_starve(cpu_starve),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_conflicts(stat_conflicts)
  );

  function automatic logic [7:0] init_byte(input int i);
    if (i == 32'h0123) return 8'hA5;
    return 8'((i * 37) ^ 8'h5C);
  endfunction

  // Synchronous single-port RAM: samples address on an edge, data next cycle.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= init_byte(i);
      ram_ready <= 1'b1;
    end else begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Transaction view: every grant schedules a completion two edges later;
  // the CPU may be granted only 4+ edges after its previous grant.
  typedef struct {
    int         due;
    bit         is_vid;
    bit         is_rd;
    logic [7:0] data;
  } ev_t;

  ev_t           evq[$];
  logic [7:0]    shadow [0:(1<<AW)-1];
  int            cyc = 0;
  int            last_grant;
  int            wait_run;
  int            conflicts;
  bit            starve;
  logic [AW-1:0] exp_mem_addr;
  logic          exp_mem_we;
  logic [DW-1:0] exp_mem_wdata, exp_vid_data, exp_cpu_rdata;
  logic          exp_vid_valid, exp_cpu_ack;

  task automatic model_clear();
    evq.delete();
    last_grant    = cyc - 8;
    wait_run      = 0;
    conflicts     = 0;
    starve        = 0;
    exp_mem_addr  = '0;
    exp_mem_we    = 0;
    exp_mem_wdata = '0;
    exp_vid_data  = '0;
    exp_cpu_rdata = '0;
    exp_vid_valid = 0;
    exp_cpu_ack   = 0;
  endtask

  task automatic model_step();
    ev_t ev;
    bit  eligible;
    cyc++;
    exp_vid_valid = 0;
    exp_cpu_ack   = 0;
    exp_mem_we    = 0;
    while (evq.size() > 0 && evq[0].due == cyc) begin
      ev = evq.pop_front();
      if (ev.is_vid) begin
        exp_vid_valid = 1;
        exp_vid_data  = ev.data;
      end else begin
        exp_cpu_ack = 1;
        if (ev.is_rd) exp_cpu_rdata = ev.data;
      end
    end
    eligible = (cyc >= last_grant + 4);
    if (vid_req && eligible && (cpu_req || wait_run > 0) && conflicts < 65535) conflicts++;
    if (vid_req) begin
      exp_mem_addr = vid_addr;
      ev.due = cyc + 2; ev.is_vid = 1; ev.is_rd = 1; ev.data = shadow[vid_addr];
      evq.push_back(ev);
    end
    if (eligible && cpu_req && !vid_req) begin
      exp_mem_addr = cpu_addr;
      exp_mem_we   = cpu_we;
      ev.due = cyc + 2; ev.is_vid = 0; ev.is_rd = !cpu_we; ev.data = shadow[cpu_addr];
      if (cpu_we) begin
        exp_mem_wdata    = cpu_wdata;
        shadow[cpu_addr] = cpu_wdata;
      end
      evq.push_back(ev);
      last_grant = cyc;
      wait_run   = 0;
    end else if (eligible && cpu_req && vid_req) begin
      if (wait_run < 31) wait_run++;
      if (wait_run >= MAX_WAIT) starve = 1;
    end else begin
      wait_run = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) shadow[i] = init_byte(i);
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    logic [15:0] exp_stat;
    forever begin
      @(posedge clk);
      #3;
`ifdef VRAM_ARB_STATS_EN
      exp_stat = 16'(conflicts);
`else
      exp_stat = 16'd0;
`endif
      check("mem_addr",   mem_addr,   exp_mem_addr);
      check("mem_we",     mem_we,     exp_mem_we);
      check("mem_wdata",  mem_wdata,  exp_mem_wdata);
      check("vid_valid",  vid_valid,  exp_vid_valid);
      check("vid_data",   vid_data,   exp_vid_data);
      check("cpu_ack",    cpu_ack,    exp_cpu_ack);
      check("cpu_rdata",  cpu_rdata,  exp_cpu_rdata);
      check("cpu_starve", cpu_starve, starve);
      check("stat",       stat_conflicts, exp_stat);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #6;
  endtask

  task automatic cpu_xfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          output int cycles);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!cpu_ack && cycles < 200);
    check("cpu_ack_seen", cpu_ack, 1'b1);
    cpu_req = 0;
    $display("cpu %s addr=0x%04h wdata=0x%02h rdata=0x%02h cycles=%0d",
             we ? "wr" : "rd", addr, wd, cpu_rdata, cycles);
  endtask

  initial begin
    int cycles, n_valid, n_ack, first_ack, second_ack, vid_pct;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles, n_valid, n_ack, first_ack, second_ack, vid_pct;

    // Reset state
    repeat (3) tick();
    check("rst_mem_addr", mem_addr, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_cpu_ack", cpu_ack, 0);

    // T1: video fetch of 0x0123
    reset = 0; vid_req = 1; vid_addr = 13'h0123;
    tick(); vid_req = 0;
    check("t1_mem_addr", mem_addr, 13'h0123);
    check("t1_mem_we", mem_we, 0);
    tick(); check("t1_no_valid_yet", vid_valid, 0);
    tick(); check("t1_vid_valid", vid_valid, 1); check("t1_vid_data", vid_data, 8'hA5);
    $display("vid rd addr=0x0123 data=0x%02h", vid_data);

    // T2: CPU write 0x5A to 0x1FFF, then read back
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h1FFF; cpu_wdata = 8'h5A;
    tick();
    check("t2_we_on", mem_we, 1); check("t2_addr", mem_addr, 13'h1FFF);
    check("t2_wdata", mem_wdata, 8'h5A); check("t2_ack_early", cpu_ack, 0);
    tick(); check("t2_we_once", mem_we, 0); check("t2_ack_k1", cpu_ack, 0);
    tick(); check("t2_ack", cpu_ack, 1); cpu_req = 0;
    $display("cpu wr addr=0x1fff wdata=0x5a");
    tick(); check("t2_ack_pulse", cpu_ack, 0);
    cpu_xfer(0, 13'h1FFF, 8'h00, cycles);
    check("t2_rdata", cpu_rdata, 8'h5A);
    check("t2_rd_latency", cycles, 3);

    // T3: simultaneous request, video continuous for 3 cycles
    tick(); tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0123; vid_req = 1; vid_addr = 13'h0040;
    tick(); tick(); tick();
    vid_req = 0;
    check("t3_vid_owns", mem_addr, 13'h0040);
    tick(); check("t3_cpu_grant", mem_addr, 13'h0123);
    tick(); check("t3_no_ack_yet", cpu_ack, 0);
    tick(); check("t3_ack", cpu_ack, 1); check("t3_rdata", cpu_rdata, 8'hA5);
    cpu_req = 0;
`ifdef VRAM_ARB_STATS_EN
    check("t3_conflicts", stat_conflicts, 3);
`else
    check("t3_conflicts", stat_conflicts, 0);
`endif
    $display("cpu rd addr=0x0123 rdata=0x%02h after 3 video cycles", cpu_rdata);

    // T4: 20 back-to-back video fetches with cpu_req held
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h1FFF;
    n_valid = 0; n_ack = 0;
    for (int i = 1; i <= 20; i++) begin
      vid_req = 1; vid_addr = 13'(i);
      tick();
      n_valid += int'(vid_valid); n_ack += int'(cpu_ack);
      if (i == 14) check("t4_starve_14", cpu_starve, 0);
      if (i == 15) check("t4_starve_15", cpu_starve, 1);
    end
    vid_req = 0;
    repeat (2) begin
      tick();
      n_valid += int'(vid_valid); n_ack += int'(cpu_ack);
    end
    check("t4_valid_count", n_valid, 20);
    check("t4_no_cpu_ack", n_ack, 0);
    tick(); check("t4_ack", cpu_ack, 1); check("t4_rdata", cpu_rdata, 8'h5A);
    cpu_req = 0;
    check("t4_starve_sticky", cpu_starve, 1);
    $display("vid burst of 20, cpu rd addr=0x1fff rdata=0x%02h starve=%0b", cpu_rdata, cpu_starve);

    // T5: CPU holds cpu_req through the ack cycle
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0123;
    first_ack = 0; second_ack = 0;
    for (int t = 1; t <= 20 && second_ack == 0; t++) begin
      tick();
      if (cpu_ack) begin
        if (first_ack == 0) first_ack = t;
        else second_ack = t;
      end
    end
    cpu_req = 0;
    check("t5_first_ack", first_ack, 3);
    check("t5_ack_spacing", second_ack - first_ack, 4);
    $display("cpu held req: acks at %0d and %0d", first_ack, second_ack);

    // T6: reset one cycle after a CPU read grant
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h1FFF;
    tick(); check("t6_grant", mem_addr, 13'h1FFF);
    tick();
    reset = 1; cpu_req = 0;
    #1;
    check("t6_rst_mem_addr", mem_addr, 0);
    check("t6_rst_cpu_ack", cpu_ack, 0);
    check("t6_rst_cpu_rdata", cpu_rdata, 0);
    check("t6_rst_vid_data", vid_data, 0);
    check("t6_rst_starve", cpu_starve, 0);
    check("t6_rst_stat", stat_conflicts, 0);
    n_ack = 0;
    repeat (2) begin tick(); n_ack += int'(cpu_ack); end
    reset = 0;
    repeat (3) begin tick(); n_ack += int'(cpu_ack); end
    check("t6_no_ack", n_ack, 0);
    cpu_xfer(0, 13'h1FFF, 8'h00, cycles);
    check("t6_after_rst_rdata", cpu_rdata, 8'h5A);
    check("t6_after_rst_latency", cycles, 3);

    // Randomized traffic, checked by the model every cycle
    vid_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: vid_pct = 0;
          1: vid_pct = 30;
          2: vid_pct = 60;
          default: vid_pct = 95;
        endcase
      end
      vid_req  = ($urandom_range(0, 99) < vid_pct);
      vid_addr = 13'($urandom_range(0, 63));
      if (cpu_req) begin
        if (cpu_ack) begin
          if ($urandom_range(0, 3) != 0) cpu_req = 0;
        end else if ($urandom_range(0, 99) == 0) begin
          cpu_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_req   = 1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 13'($urandom_range(0, 63));
        cpu_wdata = 8'($urandom);
      end
      tick();
    end
    vid_req = 0; cpu_req = 0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares one synchronous single-port video RAM (8K x 8) between the VGA pixel/attribute fetch path and the CPU bus. The video fetch has hard real-time priority. The CPU is served in the free slots through a req/ack handshake. The block sits between the video timing generator, the CPU bus decoder and the VRAM instance; all three run on the pixel clock.

Parameters:
AW, 13, address width (video fetch address and RAM address)
DW, 8, data width
CPU_MAX_WAIT, 15, CPU wait-cycle count at which the sticky starvation flag sets

Ports:
clk  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
vid_req  in  1  video fetch request, single-cycle pulse, never refused
vid_addr  in  AW  video fetch address, valid with vid_req
vid_valid  out  1  one-cycle pulse: vid_data updated
vid_data  out  DW  fetched video byte, held until next vid_valid
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  AW  CPU address; stable while cpu_req
cpu_wdata  in  DW  CPU write data; stable while cpu_req
cpu_ack  out  1  one-cycle pulse: access complete
cpu_rdata  out  DW  read data, valid with cpu_ack, held afterwards
cpu_starve  out  1  sticky: CPU waited >= CPU_MAX_WAIT cycles
mem_addr  out  AW  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_wdata  out  DW  RAM write data (registered)
mem_rdata  in  DW  RAM read data, valid the cycle after the RAM samples its address
stat_conflicts  out  16  conflict counter (see Optional Feature)

Behaviour:
- Reset (async): all outputs 0; CPU FSM = IDLE; owner pipeline empty; wait counter 0.
- Grant decision at each rising edge. Priority: vid_req > pending CPU. Result is registered into mem_addr/mem_we/mem_wdata and owner stage 1 (NONE/VID/CPU).
- Pipeline:
  - Edge k: grant.
  - Edge k+1: RAM samples; owner moves to stage 2.
  - Edge k+2: mem_rdata captured into vid_data or cpu_rdata; vid_valid or cpu_ack high for the cycle after edge k+2.
  - Fixed latency is 2 edges. Throughput is 1 grant per cycle.
- Video grant: mem_we=0, mem_addr=vid_addr. Every vid_req produces exactly one vid_valid, in order.
- Idle cycle (no grant): mem_we=0; mem_addr holds its last value.
- CPU FSM:
  - IDLE: cpu_req=1 and vid_req=0 -> grant, go to BUSY. cpu_req=1 and vid_req=1 -> WAIT, wait counter=1.
  - WAIT: vid_req=0 -> grant, go to BUSY. Otherwise stay; wait counter +1, saturating at 2^5-1.
  - BUSY: no CPU grant. At edge k+2 -> ACK (cpu_ack=1).
  - ACK: cpu_req sampled at the edge ending this cycle is ignored -> IDLE. The minimum CPU access period is therefore 4 cycles.
- CPU write grant: mem_we=1 for exactly one cycle, mem_wdata=cpu_wdata. cpu_ack still follows at k+2; cpu_rdata is unchanged on writes.
- cpu_starve sets when the wait counter reaches CPU_MAX_WAIT; cleared only by reset.
- cpu_req dropped while in WAIT (protocol violation): return to IDLE, no ack.
- No write-to-read forwarding; RAM read-during-write ordering applies.
- Reset mid-operation: in-flight accesses discarded; no vid_valid or cpu_ack is issued for them.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined: stat_conflicts counts edges where vid_req=1 and the CPU FSM is in WAIT or enters WAIT. 16-bit, saturating at 0xFFFF, cleared by reset.
- Undefined: stat_conflicts is constant 0 and no counter logic is built.

Test Plan:
- Reset release, then vid_req with vid_addr=0x0123, RAM[0x0123]=0xA5 -> mem_addr=0x0123 after edge 1; vid_valid pulse after edge 3; vid_data=0xA5.
- CPU write 0x5A to 0x1FFF with video idle -> mem_we high exactly one cycle; cpu_ack 2 edges after the grant. A following CPU read of 0x1FFF returns cpu_rdata=0x5A.
- vid_req and cpu_req asserted on the same edge, video continuous for 3 cycles -> CPU granted on the 4th edge; ack 2 edges later. stat_conflicts=3 with VRAM_ARB_STATS_EN, 0 without.
- Back-to-back vid_req every cycle for 20 cycles with cpu_req held -> 20 in-order vid_valid pulses; no cpu grant; cpu_starve=1 after 15 wait cycles and stays 1 after cpu_ack.
- CPU holds cpu_req through the ack cycle -> second access is not granted from the ignored edge; re-grant no earlier than 4 cycles after the first grant.
- Assert reset one cycle after a CPU read grant -> no cpu_ack; all outputs 0 immediately; normal operation after release.
